// File: rtl/secuenciador_notas.sv
// Melody sequencer: walks a duration ROM, gating a tone generator note by note with a silent gap after each.
// Latency: outputs are registered; each note costs dur*TICKS_POR_UNIDAD + GAP_TICKS + 1 cycles (load + tone + gap).
// Backpressure: none; pausar freezes counters and state in NOTA/PAUSA, detener aborts to idle on the next edge.
module secuenciador_notas #(
    parameter int NUM_NOTAS        = 32,
    parameter int ANCHO_DIR        = 5,
    parameter int TICKS_POR_UNIDAD = 1500000,
    parameter int GAP_TICKS        = 120000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iniciar,
    input  logic                 detener,
    input  logic                 pausar,
    input  logic                 repetir,
    input  logic [3:0]           duracion_nota,
    output logic [ANCHO_DIR-1:0] direccion_nota,
    output logic                 nota_activa,
    output logic                 reproduciendo,
    output logic                 fin
);

    // One prescaler serves both the tone units and the gap, so it is sized for the larger of the two.
    localparam int MAX_CUENTA = (TICKS_POR_UNIDAD > GAP_TICKS) ? TICKS_POR_UNIDAD : GAP_TICKS;
    localparam int ANCHO_PRE  = (MAX_CUENTA > 1) ? $clog2(MAX_CUENTA) : 1;

    localparam logic [ANCHO_PRE-1:0] FIN_UNIDAD = ANCHO_PRE'(TICKS_POR_UNIDAD - 1);
    localparam logic [ANCHO_PRE-1:0] FIN_GAP    = ANCHO_PRE'(GAP_TICKS - 1);
    localparam logic [ANCHO_PRE-1:0] UNO_PRE    = ANCHO_PRE'(1);
    localparam logic [ANCHO_DIR-1:0] ULTIMA     = ANCHO_DIR'(NUM_NOTAS - 1);
    localparam logic [ANCHO_DIR-1:0] UNO_DIR    = ANCHO_DIR'(1);

    typedef enum logic [2:0] {
        REPOSO = 3'd0,
        CARGA  = 3'd1,
        NOTA   = 3'd2,
        PAUSA  = 3'd3,
        FIN    = 3'd4
    } estado_t;

    estado_t                estado;
    estado_t                estado_sig;
    logic [ANCHO_PRE-1:0]   presc;
    logic [ANCHO_PRE-1:0]   presc_sig;
    logic [3:0]             unidades;
    logic [3:0]             unidades_sig;
    logic [ANCHO_DIR-1:0]   dir_sig;
    logic                   activa_sig;
    logic                   reproduciendo_sig;
    logic                   fin_sig;
    logic                   congelado;

    // Pause only bites while timing a note or a gap; load and end states run through regardless.
    assign congelado = pausar && ((estado == NOTA) || (estado == PAUSA));

    // State, counters and registered outputs; reset silences the speaker without waiting for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado         <= REPOSO;
            presc          <= '0;
            unidades       <= '0;
            direccion_nota <= '0;
            nota_activa    <= 1'b0;
            reproduciendo  <= 1'b0;
            fin            <= 1'b0;
        end else begin
            estado         <= estado_sig;
            presc          <= presc_sig;
            unidades       <= unidades_sig;
            direccion_nota <= dir_sig;
            nota_activa    <= activa_sig;
            reproduciendo  <= reproduciendo_sig;
            fin            <= fin_sig;
        end
    end

    // Next state, counter updates and next output values.
    always_comb begin
        estado_sig   = estado;
        presc_sig    = presc;
        unidades_sig = unidades;
        dir_sig      = direccion_nota;

        if (detener) begin
            // Abort beats everything, including a simultaneous start request.
            estado_sig   = REPOSO;
            presc_sig    = '0;
            unidades_sig = '0;
            dir_sig      = '0;
        end else if (!congelado) begin
            case (estado)
                REPOSO: begin
                    if (iniciar) begin
                        dir_sig    = '0;
                        estado_sig = CARGA;
                    end
                end

                // The ROM has had a full cycle to settle on the new address; a zero duration ends the melody.
                CARGA: begin
                    if (duracion_nota == 4'd0) begin
                        estado_sig = FIN;
                    end else begin
                        estado_sig   = NOTA;
                        unidades_sig = duracion_nota;
                        presc_sig    = '0;
                    end
                end

                NOTA: begin
                    if (presc == FIN_UNIDAD) begin
                        presc_sig = '0;
                        if (unidades <= 4'd1) begin
                            unidades_sig = '0;
                            estado_sig   = PAUSA;
                        end else begin
                            unidades_sig = unidades - 4'd1;
                        end
                    end else begin
                        presc_sig = presc + UNO_PRE;
                    end
                end

                // Gap after the note; the last slot goes to FIN so the address never wraps.
                PAUSA: begin
                    if (presc == FIN_GAP) begin
                        presc_sig = '0;
                        if (direccion_nota == ULTIMA) begin
                            estado_sig = FIN;
                        end else begin
                            dir_sig    = direccion_nota + UNO_DIR;
                            estado_sig = CARGA;
                        end
                    end else begin
                        presc_sig = presc + UNO_PRE;
                    end
                end

                FIN: begin
                    dir_sig    = '0;
                    estado_sig = repetir ? CARGA : REPOSO;
                end

                default: begin
                    estado_sig   = REPOSO;
                    presc_sig    = '0;
                    unidades_sig = '0;
                    dir_sig      = '0;
                end
            endcase
        end

        // A frozen note stays in NOTA but must be silent for that cycle.
        activa_sig        = (estado_sig == NOTA) && !congelado;
        reproduciendo_sig = (estado_sig != REPOSO);
        fin_sig           = (estado_sig == FIN);
    end

endmodule

// File: tb/tb_secuenciador_notas.sv
// Directed bench for secuenciador_notas with short timing (4 ticks/unit, 2-tick gap, 4 slots).
// Cycle-by-cycle vector table plus hand sequences for pause, async reset and restart.
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
module tb_secuenciador_notas;

    localparam int T  = 4;
    localparam int G  = 2;
    localparam int N  = 4;
    localparam int AD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          iniciar;
    logic          detener;
    logic          pausar;
    logic          repetir;
    logic [3:0]    duracion_nota;
    logic [AD-1:0] direccion_nota;
    logic          nota_activa;
    logic          reproduciendo;
    logic          fin;

    logic [3:0]    rom [0:3];
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    assign duracion_nota = rom[direccion_nota];

    secuenciador_notas #(
        .NUM_NOTAS       (N),
        .ANCHO_DIR       (AD),
        .TICKS_POR_UNIDAD(T),
        .GAP_TICKS       (G)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .iniciar       (iniciar),
        .detener       (detener),
        .pausar        (pausar),
        .repetir       (repetir),
        .duracion_nota (duracion_nota),
        .direccion_nota(direccion_nota),
        .nota_activa   (nota_activa),
        .reproduciendo (reproduciendo),
        .fin           (fin)
    );

    typedef struct {
        logic          ini;
        logic          det;
        logic          pau;
        logic          rep;
        logic [15:0]   mel;
        logic [AD-1:0] e_dir;
        logic          e_act;
        logic          e_rep;
        logic          e_fin;
    } vec_t;

    vec_t        tabla[$];
    logic [15:0] mel_act;

    function automatic void agrega(input int n, input logic ini, input logic det,
                                   input logic pau, input logic rep, input int d,
                                   input logic a, input logic r, input logic f);
        vec_t v;
        v.ini   = ini;
        v.det   = det;
        v.pau   = pau;
        v.rep   = rep;
        v.mel   = mel_act;
        v.e_dir = AD'(d);
        v.e_act = a;
        v.e_rep = r;
        v.e_fin = f;
        for (int k = 0; k < n; k++) tabla.push_back(v);
    endfunction

    task automatic carga_rom(input logic [15:0] m);
        for (int k = 0; k < 4; k++) rom[k] = m[4*k +: 4];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nom, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nom, got, want);
        end
    endtask

    int high_cnt;
    int fin_cnt;

    initial begin
        // ---------------- vector table ----------------
        // detener wins over iniciar in REPOSO
        mel_act = 16'h0000;
        agrega(1, 1, 1, 0, 0, 0, 0, 0, 0);
        // zero duration at slot 0: CARGA then FIN, no tone; pausar in REPOSO is ignored
        agrega(1, 1, 0, 1, 0, 0, 0, 1, 0);
        agrega(1, 0, 0, 0, 0, 0, 0, 1, 1);
        agrega(2, 0, 0, 0, 0, 0, 0, 0, 0);
        // durations [2,1,0,x], single pass
        mel_act = 16'h0012;
        agrega(1, 1, 0, 0, 0, 0, 0, 1, 0);   // CARGA 0
        agrega(2, 0, 0, 0, 0, 0, 1, 1, 0);   // NOTA 0
        agrega(1, 1, 0, 0, 0, 0, 1, 1, 0);   // iniciar ignored mid-note
        agrega(5, 0, 0, 0, 0, 0, 1, 1, 0);   // 8 high cycles in total
        agrega(2, 0, 0, 0, 0, 0, 0, 1, 0);   // gap
        agrega(1, 0, 0, 0, 0, 1, 0, 1, 0);   // CARGA 1
        agrega(1, 0, 0, 1, 0, 1, 1, 1, 0);   // pausar during CARGA has no effect
        agrega(3, 0, 0, 0, 0, 1, 1, 1, 0);   // 4 high cycles at addr 1
        agrega(2, 0, 0, 0, 0, 1, 0, 1, 0);   // gap
        agrega(1, 0, 0, 0, 0, 2, 0, 1, 0);   // CARGA 2 (duration 0)
        agrega(1, 0, 0, 0, 0, 2, 0, 1, 1);   // FIN pulse
        agrega(1, 0, 0, 1, 0, 0, 0, 0, 0);   // back to REPOSO, pausar in FIN ignored
        agrega(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // durations [1,1,1,1] with repetir: all four slots, FIN, restart
        mel_act = 16'h1111;
        agrega(1, 1, 0, 0, 1, 0, 0, 1, 0);
        for (int a = 0; a < 4; a++) begin
            agrega(4, 0, 0, 0, 1, a, 1, 1, 0);
            agrega(2, 0, 0, 0, 1, a, 0, 1, 0);
            if (a < 3) agrega(1, 0, 0, 0, 1, a + 1, 0, 1, 0);
        end
        agrega(1, 0, 0, 0, 1, 3, 0, 1, 1);   // FIN after slot 3, no CARGA at slot 4
        agrega(1, 0, 0, 0, 1, 0, 0, 1, 0);   // restart at slot 0
        for (int a = 0; a < 2; a++) begin
            agrega(4, 0, 0, 0, 1, a, 1, 1, 0);
            agrega(2, 0, 0, 0, 1, a, 0, 1, 0);
            agrega(1, 0, 0, 0, 1, a + 1, 0, 1, 0);
        end
        agrega(2, 0, 0, 0, 1, 2, 1, 1, 0);   // mid-note at slot 2
        agrega(1, 0, 1, 0, 1, 0, 0, 0, 0);   // detener: idle, addr 0, no fin
        agrega(2, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- reset state ----------------
        rst     = 1'b1;
        iniciar = 1'b0;
        detener = 1'b0;
        pausar  = 1'b0;
        repetir = 1'b0;
        carga_rom(16'h0000);
        #3;
        chk("rst_dir", direccion_nota, 0);
        chk("rst_act", nota_activa, 0);
        chk("rst_rep", reproduciendo, 0);
        chk("rst_fin", fin, 0);
        tick;
        rst = 1'b0;

        // ---------------- apply table ----------------
        foreach (tabla[i]) begin
            iniciar = tabla[i].ini;
            detener = tabla[i].det;
            pausar  = tabla[i].pau;
            repetir = tabla[i].rep;
            carga_rom(tabla[i].mel);
            tick;
            chk($sformatf("v%0d_dir", i), direccion_nota, tabla[i].e_dir);
            chk($sformatf("v%0d_act", i), nota_activa,    tabla[i].e_act);
            chk($sformatf("v%0d_rep", i), reproduciendo,  tabla[i].e_rep);
            chk($sformatf("v%0d_fin", i), fin,            tabla[i].e_fin);
        end
        iniciar = 1'b0;
        detener = 1'b0;
        pausar  = 1'b0;
        repetir = 1'b0;

        // ---------------- pause in the middle of a 3-unit note ----------------
        carga_rom(16'h0003);
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
        chk("pau_carga_act", nota_activa, 0);
        tick;
        chk("pau_c1_act", nota_activa, 1);
        high_cnt = 1;
        pausar = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk($sformatf("pau_frz%0d_act", k), nota_activa, 0);
            chk($sformatf("pau_frz%0d_rep", k), reproduciendo, 1);
        end
        pausar  = 1'b0;
        fin_cnt = 0;
        for (int k = 0; k < 40 && fin_cnt == 0; k++) begin
            tick;
            if (nota_activa) high_cnt++;
            if (fin) fin_cnt++;
        end
        chk("pau_high_total", high_cnt, 12);
        chk("pau_fin_seen", fin_cnt, 1);
        tick;
        chk("pau_idle_rep", reproduciendo, 0);

        // ---------------- async reset mid-note at slot 1 ----------------
        carga_rom(16'h0021);
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
        for (int k = 0; k < 9; k++) tick;
        chk("ar_pre_dir", direccion_nota, 1);
        chk("ar_pre_act", nota_activa, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_act", nota_activa, 0);
        chk("ar_rep", reproduciendo, 0);
        chk("ar_dir", direccion_nota, 0);
        rst = 1'b0;
        tick;
        chk("ar_wait_rep", reproduciendo, 0);
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
        chk("ar_restart_dir", direccion_nota, 0);
        chk("ar_restart_rep", reproduciendo, 1);
        tick;
        chk("ar_restart_act", nota_activa, 1);
        chk("ar_restart_dir2", direccion_nota, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
